// File: rtl/regfile_ctrl_pkg.sv
// Shared register-file control types and constants for the writeback arbiter slice.
package regfile_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] addr_onehot(input reg_addr_t a);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_chk.sv
// Protocol checker: a register-file write must retire an outstanding scoreboard entry.
module regfile_wb_arbiter_chk #(
  parameter int CNT_W = 2
) (
  input logic             Clk,
  input logic             Rst_n,
  input logic             Reg_Write,
  input logic [CNT_W-1:0] Wr_Cnt
);

  wr_has_pending_a: assert property (@(posedge Clk) disable iff (!Rst_n)
    Reg_Write |-> (Wr_Cnt != {CNT_W{1'b0}}));

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter: round-robin by default, fixed priority (lowest index wins) when
// WB_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [N-1:0] Req,
  input  logic         Advance,
  output logic [N-1:0] Grant
);

  logic found_s;

`ifdef WB_ARB_FIXED_PRIO_EN
  logic unused_s;
  assign unused_s = ^{Clk, Rst_n, Advance};

  // Lowest-index requester wins.
  always_comb begin
    Grant   = {N{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (Req[i] && !found_s) begin
        Grant[i] = 1'b1;
        found_s  = 1'b1;
      end else begin
        Grant[i] = Grant[i];
      end
    end
  end
`else
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_nxt_s;
  int            idx_s;

  // Search from the pointer, wrapping; the winner's successor becomes the next pointer.
  always_comb begin
    Grant     = {N{1'b0}};
    found_s   = 1'b0;
    ptr_nxt_s = ptr_r;
    idx_s     = 0;
    for (int k = 0; k < N; k++) begin
      idx_s = (int'(ptr_r) + k) % N;
      if (Req[idx_s] && !found_s) begin
        Grant[idx_s] = 1'b1;
        found_s      = 1'b1;
        ptr_nxt_s    = PW'((idx_s + 1) % N);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves only on an accepted grant.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ptr_r <= {PW{1'b0}};
    end else if (Advance) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with per-register pending-write scoreboard.
// Build option: WB_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int CNT_W = 2
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic [N_REQ-1:0]                Req_Valid,
  input  logic [N_REQ-1:0][REG_ADDR_W-1:0] Req_Addr,
  input  logic [N_REQ-1:0][XLEN-1:0]      Req_Data,
  output logic [N_REQ-1:0]                Req_Ready,
  input  logic                            Issue_Valid,
  input  reg_addr_t                       Issue_Rd,
  output logic                            Issue_Ready,
  input  reg_addr_t                       Rs1_Addr,
  input  reg_addr_t                       Rs2_Addr,
  output logic                            Rs1_Busy,
  output logic                            Rs2_Busy,
  output logic                            Reg_Write,
  output reg_addr_t                       Wr_Address,
  output logic [XLEN-1:0]                 Wr_Data
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_REQ-1:0]    req_valid_s;
  logic [N_REQ-1:0]    grant_s;
  logic                accept_s;
  wb_req_t             sel_s;
  logic [CNT_W-1:0]    cnt_r [NUM_REGS];
  logic [NUM_REGS-1:0] inc_s;
  logic [NUM_REGS-1:0] dec_s;

  assign req_valid_s = Rst_n ? Req_Valid : {N_REQ{1'b0}};
  assign accept_s    = |grant_s;
  assign Req_Ready   = grant_s;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Req     (req_valid_s),
    .Advance (accept_s),
    .Grant   (grant_s)
  );

  // Route the granted requester's payload.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s[i]) begin
        sel_s.addr = Req_Addr[i];
        sel_s.data = Req_Data[i];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Write-port registers; x0 writes are consumed without touching the port.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Reg_Write  <= 1'b0;
      Wr_Address <= 5'd0;
      Wr_Data    <= 32'd0;
    end else if (accept_s && (sel_s.addr != 5'd0)) begin
      Reg_Write  <= 1'b1;
      Wr_Address <= sel_s.addr;
      Wr_Data    <= sel_s.data;
    end else begin
      Reg_Write  <= 1'b0;
      Wr_Address <= Wr_Address;
      Wr_Data    <= Wr_Data;
    end
  end

  assign Issue_Ready = Rst_n && (cnt_r[Issue_Rd] != CNT_MAX);
  assign inc_s = (Issue_Valid && Issue_Ready)
               ? (addr_onehot(Issue_Rd) & {{(NUM_REGS-1){1'b1}}, 1'b0})
               : {NUM_REGS{1'b0}};
  assign dec_s = Reg_Write ? addr_onehot(Wr_Address) : {NUM_REGS{1'b0}};

  // Pending-write counters; a same-cycle issue and retire cancel out.
  always_ff @(posedge Clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (!Rst_n) begin
        cnt_r[r] <= {CNT_W{1'b0}};
      end else if (inc_s[r] && !dec_s[r]) begin
        cnt_r[r] <= cnt_r[r] + CNT_ONE;
      end else if (dec_s[r] && !inc_s[r] && (cnt_r[r] != {CNT_W{1'b0}})) begin
        cnt_r[r] <= cnt_r[r] - CNT_ONE;
      end else begin
        cnt_r[r] <= cnt_r[r];
      end
    end
  end

  // A last pending write landing this cycle is visible through the regfile bypass.
  assign Rs1_Busy = Rst_n && (Rs1_Addr != 5'd0) && (cnt_r[Rs1_Addr] != {CNT_W{1'b0}}) &&
                    !(Reg_Write && (Wr_Address == Rs1_Addr) && (cnt_r[Rs1_Addr] == CNT_ONE));
  assign Rs2_Busy = Rst_n && (Rs2_Addr != 5'd0) && (cnt_r[Rs2_Addr] != {CNT_W{1'b0}}) &&
                    !(Reg_Write && (Wr_Address == Rs2_Addr) && (cnt_r[Rs2_Addr] == CNT_ONE));

  regfile_wb_arbiter_chk #(.CNT_W(CNT_W)) u_chk (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Reg_Write (Reg_Write),
    .Wr_Cnt    (cnt_r[Wr_Address])
  );

endmodule
